rotor_ftob_diff_test: RTL and testbench
=======================================

// Module: rotor_ftob_diff_test
// PURPOSE
//   Enigma scrambler core for a full signal path.
//   Forward path: rotor0 -> rotor1 -> rotor2 -> reflector.
//   Backward path: rotor2^-1 -> rotor1^-1 -> rotor0^-1.
//   Rotor wiring is held as per-contact offset ("diff") tables. Rotor positions are inputs; stepping is done upstream.
//   Sits between the plugboard and the stepping/keyboard logic of the Enigma datapath.
// PARAMETERS
//   none. The letter count N=26 and the wiring tables are fixed constants in the shared package.
// PORTS
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  reset, asynchronous, active-low
//   data_in      in   6  input letter code, 0=A .. 25=Z
//   r0_position  in   6  rotor0 (rightmost, first hit) position, 0..25
//   r1_position  in   6  rotor1 (middle) position, 0..25
//   r2_position  in   6  rotor2 (leftmost) position, 0..25
//   data_out     out  6  scrambled letter code, 0..25; 63 = invalid input
// BEHAVIOUR
//   - Clock and reset: one clock; reset is asynchronous and active-low.
//     While rst_n=0, data_out=0.
//   - Latency: the whole path is combinational from the input ports to one output register.
//     data_out updates on the clk edge after its inputs are sampled (1-cycle latency, one result per cycle, no handshake).
//   - Wiring: rotor0=Enigma III, rotor1=II, rotor2=I, reflector=UKW-B. Ring settings are fixed at A.
//     III = BDFHJLCPRTXVZNYEIWGAKMUSQO
//     II  = AJDKSIRUXBLHWTMCQGZNPYFVOE
//     I   = EKMFLGDQVZNTOWYHXUSPAIBRCJ
//     UKW-B = YRUHQSLDPXNGOKMIEBFZCWVJAT
//   - Diff tables:
//     FWD[i] = (W[i]-i) mod 26
//     BWD[j] = (i-j) mod 26, where W[i]=j
//     REF[i] = (R[i]-i) mod 26
//   - Rotor stage, position p, input x:
//     out = (x + T[(x+p) mod 26]) mod 26
//     T = FWD on the forward pass, BWD on the backward pass.
//     Reflector: out = (x + REF[x]) mod 26.
//   - Arithmetic: all mod-26 sums are formed in 6 bits.
//     Each sum is at most 25+25 = 50, so it is reduced by a single conditional subtract of 26.
//   - Positions 26..63 are reduced modulo 26 before use.
//     Example: 26 -> 0, 63 -> 11.
//   - data_in 26..63 is invalid: data_out = 63 and no table lookup is used.
//   - Involution: for fixed positions, f(f(x)) = x, and f(x) != x for every valid x.
//   - Positions or data that change mid-stream simply take effect on the next clock edge. There is no internal state besides data_out.
//   - Reset asserted mid-operation clears data_out to 0 immediately.
//     The first valid result appears on the first clk edge after rst_n rises.
// STRUCTURE
//   - Package enigma_pkg holds:
//     letter count N_LETTERS=26 and INVALID_CODE=6'd63;
//     the function mod26_add(a,b);
//     constant diff tables ROTOR_I/II/III_FWD, ROTOR_I/II/III_BWD and UKW_B_DIFF (26 x 5-bit entries each).
//   - One sub-module, rotor_stage: inputs x, p, dir; output y.
//     It is instantiated 6 times, with table selection by a rotor-id parameter.
//     The reflector is inline logic in the top module.
// TESTING
//   1. rst_n=0, any inputs -> data_out=0. Release reset, data_in=0, positions 0,0,0 -> data_out=20 (A->U) one edge later.
//   2. Involution check: data_in=20, positions 0,0,0 -> data_out=0. Sweep all 26 inputs at 0,0,0: every output is valid, no fixed point, f(f(x))=x.
//   3. data_in=0, r0=1, r1=0, r2=0 -> data_out=1 (A->B, the classic AAB result). Then data_in=1 -> 0.
//   4. Position wrap: r0=26 gives the same result as r0=0. r0=27 gives the same as r0=1 (data_in=0 -> 1).
//   5. Invalid input: data_in=26 and data_in=63 -> data_out=63 for any positions.
//   6. Reset mid-stream: pulse rst_n low between clk edges -> data_out drops to 0 asynchronously, then resumes correct values.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter constants, mod-26 adder and rotor/reflector diff tables
package enigma_pkg;
  localparam int N_LETTERS = 26;
  localparam logic [5:0] INVALID_CODE = 6'd63;
  typedef enum logic [1:0] {RID_I, RID_II, RID_III} rotor_id_e;
  typedef enum logic {DIR_FWD, DIR_BWD} dir_e;
  localparam logic [4:0] ROTOR_I_FWD [26] = '{4, 9, 10, 2, 7, 1, 23, 9, 13, 16, 3, 8, 2, 9, 10, 18, 7, 3, 0, 22, 6, 13, 5, 20, 4, 10};
  localparam logic [4:0] ROTOR_I_BWD [26] = '{20, 21, 22, 3, 22, 24, 25, 8, 13, 16, 17, 19, 16, 23, 24, 4, 17, 6, 0, 18, 23, 13, 17, 19, 16, 10};
  localparam logic [4:0] ROTOR_II_FWD [26] = '{0, 8, 1, 7, 14, 3, 11, 13, 15, 18, 1, 22, 10, 6, 24, 13, 0, 15, 7, 20, 21, 3, 9, 24, 16, 5};
  localparam logic [4:0] ROTOR_II_BWD [26] = '{0, 8, 13, 25, 21, 17, 11, 4, 23, 18, 19, 25, 2, 6, 10, 5, 0, 15, 12, 20, 13, 2, 16, 11, 23, 19};
  localparam logic [4:0] ROTOR_III_FWD [26] = '{1, 2, 3, 4, 5, 6, 22, 8, 9, 10, 13, 10, 13, 0, 10, 15, 18, 5, 14, 7, 16, 17, 24, 21, 18, 15};
  localparam logic [4:0] ROTOR_III_BWD [26] = '{19, 25, 4, 24, 11, 23, 12, 22, 8, 21, 10, 20, 9, 0, 11, 18, 8, 17, 5, 16, 2, 16, 21, 13, 16, 13};
  localparam logic [4:0] UKW_B_DIFF [26] = '{24, 16, 18, 4, 12, 13, 5, 22, 7, 14, 3, 21, 2, 23, 24, 19, 14, 10, 13, 6, 8, 1, 25, 12, 2, 20};
  function automatic logic [5:0] mod26_add(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] s;
    s = a + b;
    return (s >= 6'(N_LETTERS)) ? s - 6'(N_LETTERS) : s;
  endfunction
endpackage

// File: rtl/rotor_stage.sv
// rotor_stage: one rotor contact mapping, y = x + T[(x+p) mod 26] mod 26
module rotor_stage
  import enigma_pkg::*;
#(
  parameter rotor_id_e RID = RID_I
) (
  input  logic [5:0] x,
  input  logic [5:0] p,
  input  dir_e       dir,
  output logic [5:0] y
);
  logic [4:0] i, fw, bw, t;
  assign i = 5'(mod26_add(x, p));
  assign fw = RID == RID_I ? ROTOR_I_FWD[i] : RID == RID_II ? ROTOR_II_FWD[i] : ROTOR_III_FWD[i];
  assign bw = RID == RID_I ? ROTOR_I_BWD[i] : RID == RID_II ? ROTOR_II_BWD[i] : ROTOR_III_BWD[i];
  assign t = dir == DIR_BWD ? bw : fw;
  assign y = mod26_add(x, {1'b0, t});
endmodule

// File: rtl/rotor_ftob_diff_test.sv
// rotor_ftob_diff_test: registered Enigma scrambler, III-II-I rotors with UKW-B reflector
module rotor_ftob_diff_test
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] data_in,
  input  logic [5:0] r0_position,
  input  logic [5:0] r1_position,
  input  logic [5:0] r2_position,
  output logic [5:0] data_out
);
  function automatic logic [5:0] red26(input logic [5:0] v);
    return v >= 6'd52 ? v - 6'd52 : v >= 6'd26 ? v - 6'd26 : v;
  endfunction
  logic       valid;
  logic [5:0] x, p0, p1, p2, f0, f1, f2, rf, b2, b1, b0, data_d, data_q;
  assign valid = data_in < 6'd26;
  assign x = valid ? data_in : 6'd0;
  assign p0 = red26(r0_position);
  assign p1 = red26(r1_position);
  assign p2 = red26(r2_position);
  rotor_stage #(.RID(RID_III)) u_f0 (.x(x),  .p(p0), .dir(DIR_FWD), .y(f0));
  rotor_stage #(.RID(RID_II))  u_f1 (.x(f0), .p(p1), .dir(DIR_FWD), .y(f1));
  rotor_stage #(.RID(RID_I))   u_f2 (.x(f1), .p(p2), .dir(DIR_FWD), .y(f2));
  assign rf = mod26_add(f2, {1'b0, UKW_B_DIFF[5'(f2)]});
  rotor_stage #(.RID(RID_I))   u_b2 (.x(rf), .p(p2), .dir(DIR_BWD), .y(b2));
  rotor_stage #(.RID(RID_II))  u_b1 (.x(b2), .p(p1), .dir(DIR_BWD), .y(b1));
  rotor_stage #(.RID(RID_III)) u_b0 (.x(b1), .p(p0), .dir(DIR_BWD), .y(b0));
  assign data_d = valid ? b0 : INVALID_CODE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= 6'd0;
    else data_q <= data_d;
  assign data_out = data_q;
endmodule

// File: tb/tb_rotor_ftob_diff_test.sv
// tb_rotor_ftob_diff_test: scoreboard bench for the Enigma scrambler core
module tb_rotor_ftob_diff_test;
  typedef struct {
    logic [5:0] d;
    string      nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] data_in = '0, r0 = '0, r1 = '0, r2 = '0;
  logic [5:0] data_out;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  string w_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string w_ii = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  string w_iii = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  string ukw = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  rotor_ftob_diff_test dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .r0_position(r0), .r1_position(r1), .r2_position(r2), .data_out(data_out)
  );
  always #5 clk = ~clk;
  function automatic int fw(string w, int x, int p);
    return ((int'(w[(x + p) % 26]) - 65) - p + 26) % 26;
  endfunction
  function automatic int bw(string w, int x, int p);
    int c = (x + p) % 26;
    for (int j = 0; j < 26; j++)
      if (int'(w[j]) - 65 == c) return (j - p + 26) % 26;
    return 0;
  endfunction
  function automatic logic [5:0] model(int x, int p0, int p1, int p2);
    int v;
    if (x > 25) return 6'd63;
    p0 %= 26;
    p1 %= 26;
    p2 %= 26;
    v = fw(w_iii, x, p0);
    v = fw(w_ii, v, p1);
    v = fw(w_i, v, p2);
    v = int'(ukw[v]) - 65;
    v = bw(w_i, v, p2);
    v = bw(w_ii, v, p1);
    v = bw(w_iii, v, p0);
    return 6'(v);
  endfunction
  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: data_out=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic apply(input int d, input int a, input int b, input int c, input logic [5:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    data_in = 6'(d);
    r0 = 6'(a);
    r1 = 6'(b);
    r2 = 6'(c);
    e.d = exp;
    e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check(e.nm, data_out, e.d);
      end
    end
  end
  initial begin
    logic [5:0] y;
    data_in = 6'd7;
    r0 = 6'd3;
    r1 = 6'd9;
    r2 = 6'd14;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", data_out, 6'd0);
    @(negedge clk) rst_n = 1'b1;
    apply(0, 0, 0, 0, 6'd20, "a_to_u");
    apply(20, 0, 0, 0, 6'd0, "u_to_a");
    for (int x = 0; x < 26; x++) begin
      y = model(x, 0, 0, 0);
      apply(x, 0, 0, 0, y, "sweep");
      apply(int'(y), 0, 0, 0, 6'(x), "involution");
    end
    apply(0, 1, 0, 0, 6'd1, "aab");
    apply(1, 1, 0, 0, 6'd0, "b_back");
    apply(0, 26, 0, 0, 6'd20, "wrap26");
    apply(0, 27, 0, 0, 6'd1, "wrap27");
    apply(0, 63, 0, 0, model(0, 11, 0, 0), "wrap63");
    for (int x = 0; x < 26; x += 5) begin
      y = model(x, 5, 17, 9);
      apply(x, 5, 17, 9, y, "pos_mix");
      apply(int'(y), 31, 43, 61, 6'(x), "pos_mix_inv");
    end
    apply(7, 40, 52, 63, model(7, 14, 0, 11), "wrap_all");
    apply(26, 3, 4, 5, 6'd63, "invalid26");
    apply(63, 0, 0, 0, 6'd63, "invalid63");
    apply(45, 63, 63, 63, 6'd63, "invalid45");
    apply(0, 0, 0, 0, 6'd20, "pre_reset");
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", data_out, 6'd0);
    #1 rst_n = 1'b1;
    apply(0, 1, 0, 0, 6'd1, "post_reset_aab");
    apply(20, 0, 0, 0, 6'd0, "post_reset_u");
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
